// File: rtl/uart_rcv_cmd_pkg.sv
// rtl/uart_rcv_cmd_pkg.sv - shared constants for the UART command receiver
// Command codes, ASCII characters and FSM state encoding.
package uart_rcv_cmd_pkg;

   localparam logic [1:0] CMD_READ  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_GO    = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_R  = 8'h72;
   localparam logic [7:0] ASCII_W  = 8'h77;
   localparam logic [7:0] ASCII_G  = 8'h67;
   localparam logic [7:0] ASCII_Q  = 8'h71;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_QEND = 3'd3,
      ST_ERR  = 3'd4
   } state_e;

endpackage

// File: rtl/uart_rcv_cmd_hex_ascii_dec.sv
// rtl/uart_rcv_cmd_hex_ascii_dec.sv - ASCII character classifier
// Flags hex digits (with nibble value), the separator and line terminators.
module hex_ascii_dec (
   input  logic [7:0] rx_char,
   output logic       is_hex,
   output logic [3:0] nibble,
   output logic       is_sp,
   output logic       is_eol
);
   import uart_rcv_cmd_pkg::*;

   always_comb begin
      is_hex = 1'b0;
      nibble = 4'h0;
      if (rx_char >= 8'h30 && rx_char <= 8'h39) begin
         is_hex = 1'b1;
         nibble = rx_char[3:0];
      end else if ((rx_char >= 8'h41 && rx_char <= 8'h46) ||
                   (rx_char >= 8'h61 && rx_char <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 lands on 0xA
         is_hex = 1'b1;
         nibble = rx_char[3:0] + 4'd9;
      end
   end

   assign is_sp  = (rx_char == ASCII_SP);
   assign is_eol = (rx_char == ASCII_CR) || (rx_char == ASCII_LF);

endmodule

// File: rtl/uart_rcv_cmd.sv
// rtl/uart_rcv_cmd.sv - parses ASCII command lines into read/write/go/stop commands
// One character is consumed per rx_en strobe; results pulse the cycle after the terminator.
module uart_rcv_cmd (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_char,
   input  logic        rx_en,
   input  logic        cmd_busy,
   output logic        cmd_valid,
   output logic [1:0]  cmd_code,
   output logic [31:0] cmd_addr,
   output logic [31:0] cmd_wdata,
   output logic        cmd_err,
   output logic        crlf_out
);
   import uart_rcv_cmd_pkg::*;

   state_e      state_q;
   logic [1:0]  code_q;
   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [31:0] addr_q;
   logic [3:0]  cnt_q;
   logic        cmd_valid_q;
   logic [1:0]  cmd_code_q;
   logic [31:0] cmd_addr_q;
   logic [31:0] cmd_wdata_q;
   logic        cmd_err_q;
   logic        crlf_q;

   logic        is_hex;
   logic [3:0]  nibble;
   logic        is_sp;
   logic        is_eol;

   hex_ascii_dec u_dec (
      .rx_char (rx_char),
      .is_hex  (is_hex),
      .nibble  (nibble),
      .is_sp   (is_sp),
      .is_eol  (is_eol)
   );

   assign acc_d = {acc_q[27:0], nibble};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= CMD_READ;
         acc_q       <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= CMD_READ;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_err_q   <= 1'b0;
         crlf_q      <= 1'b0;
      end else begin
         cmd_valid_q <= 1'b0;
         cmd_err_q   <= 1'b0;
         crlf_q      <= 1'b0;
         if (rx_en) begin
            if (cmd_busy) begin
               state_q <= ST_ERR;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (is_sp || is_eol) begin
                        state_q <= ST_IDLE;
                     end else if (rx_char == ASCII_R || rx_char == ASCII_W || rx_char == ASCII_G) begin
                        code_q  <= (rx_char == ASCII_R) ? CMD_READ :
                                   (rx_char == ASCII_W) ? CMD_WRITE : CMD_GO;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ADDR;
                     end else if (rx_char == ASCII_Q) begin
                        state_q <= ST_QEND;
                     end else begin
                        state_q <= ST_ERR;
                     end
                  end
                  ST_ADDR, ST_DATA: begin
                     if (is_hex) begin
                        if (cnt_q == 4'd8) begin
                           state_q <= ST_ERR;
                        end else begin
                           acc_q <= acc_d;
                           cnt_q <= cnt_q + 4'd1;
                        end
                     end else if (is_sp) begin
                        if (cnt_q == 4'd0) begin
                           state_q <= state_q;
                        end else if (state_q == ST_ADDR && code_q == CMD_WRITE) begin
                           addr_q  <= acc_q;
                           acc_q   <= '0;
                           cnt_q   <= '0;
                           state_q <= ST_DATA;
                        end else begin
                           state_q <= ST_ERR;
                        end
                     end else if (is_eol && cnt_q != 4'd0 &&
                                  ((state_q == ST_ADDR) != (code_q == CMD_WRITE))) begin
                        // Reads and writes must be word aligned; go has no such rule
                        state_q <= ST_IDLE;
                        if (state_q == ST_DATA) begin
                           if (addr_q[1:0] != 2'b00) begin
                              cmd_err_q <= 1'b1;
                              crlf_q    <= 1'b1;
                           end else begin
                              cmd_valid_q <= 1'b1;
                              cmd_code_q  <= CMD_WRITE;
                              cmd_addr_q  <= addr_q;
                              cmd_wdata_q <= acc_q;
                              crlf_q      <= 1'b1;
                           end
                        end else if (code_q == CMD_READ && acc_q[1:0] != 2'b00) begin
                           cmd_err_q <= 1'b1;
                           crlf_q    <= 1'b1;
                        end else begin
                           cmd_valid_q <= 1'b1;
                           cmd_code_q  <= code_q;
                           cmd_addr_q  <= acc_q;
                           crlf_q      <= (code_q != CMD_READ);
                        end
                     end else begin
                        state_q <= ST_ERR;
                     end
                  end
                  ST_QEND: begin
                     if (is_eol) begin
                        cmd_valid_q <= 1'b1;
                        cmd_code_q  <= CMD_STOP;
                        crlf_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                     end else begin
                        state_q <= ST_ERR;
                     end
                  end
                  ST_ERR: begin
                     if (is_eol) begin
                        cmd_err_q <= 1'b1;
                        crlf_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                     end
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_addr  = cmd_addr_q;
   assign cmd_wdata = cmd_wdata_q;
   assign cmd_err   = cmd_err_q;
   assign crlf_out  = crlf_q;

endmodule
